mmio_fifo_port: RTL and testbench
=================================

Name: mmio_fifo_port

Overview:
- Memory-mapped responder on the core's data-memory bus (mem_read/mem_write, addr, write data, read data), the target end of the core's load/store initiator.
- Core stores push words into a TX FIFO, drained by an external valid/ready consumer.
- An external valid/ready producer fills an RX FIFO, which core loads pop.
- Sits beside the data RAM; the top-level mux selects o_rdata when o_hit=1.

Parameters:
BASE_ADDR, 32'hFFFF_0000, register block base; bits [3:0] must be zero.
DEPTH, 8, entries per FIFO; power of 2, minimum 2.
DW, 32, data width.

Ports:
clk  in  1  single clock, rising edge.
reset  in  1  synchronous, active-high reset.
addr  in  32  core data address (ALU result).
mem_read  in  1  core load strobe.
mem_write  in  1  core store strobe.
i_wdata  in  32  core store data.
o_rdata  out  32  load data; combinational from addr and state.
o_hit  out  1  addr decodes to this block.
tx_data  out  DW  TX FIFO head.
tx_valid  out  1  TX FIFO non-empty.
tx_ready  in  1  consumer accepts head this cycle.
rx_data  in  DW  producer word.
rx_valid  in  1  producer word present.
rx_ready  out  1  RX FIFO not full.

Behaviour:
- Interface: one clock clk; reset is synchronous and active-high.
- Reset: both FIFOs empty; pointers and counts 0; sticky flags 0; tx_valid=0; rx_ready=1.
- Decode:
  - o_hit=1 when addr[31:4]==BASE_ADDR[31:4] and addr[1:0]==0.
  - Offsets: 0x0 TXDATA (W), 0x4 RXDATA (R), 0x8 STATUS (R), 0xC CTRL (W).
  - A write to a read-only offset, or a read of a write-only offset, has no effect; the read returns 0.
  - mem_read and mem_write both high: no state change; o_rdata still driven.
- Loads (core is single-cycle):
  - o_rdata is combinational in the same cycle.
  - An RXDATA read returns the RX head and pops it at the next rising edge.
  - RXDATA read while RX empty: returns 0, no pop, sets rx_udf sticky.
- Stores: TXDATA write pushes i_wdata at the rising edge.
  - If TX is full and tx_ready is not popping in the same cycle: word dropped, tx_ovf sticky set.
  - If TX is full and tx_ready pops in the same cycle: push accepted, count unchanged.
- STATUS layout:
  - [0] tx_empty, [1] tx_full, [2] rx_empty, [3] rx_full.
  - [4] tx_ovf, [5] rx_udf, [6] rx_ovf.
  - [15:8] tx_count, [23:16] rx_count (zero-extended); all other bits 0.
- CTRL bits: [0] flush TX, [1] flush RX, [2] clear all stickies.
  - Flush empties the FIFO in one cycle and beats a simultaneous push or pop on that FIFO.
  - Sticky clear beats a simultaneous sticky set.
- Stream sides: transfer when valid&&ready at the rising edge.
  - rx_valid while RX full: word not stored, rx_ovf set (rx_ready=0 signals the condition).
- FIFO mechanics:
  - Pointers are log2(DEPTH) bits and wrap modulo DEPTH.
  - Count is log2(DEPTH)+1 bits, range 0..DEPTH.
  - Simultaneous push and pop on a non-empty FIFO leaves count unchanged.
  - Pop on empty and push on full (without a same-cycle pop) are no-ops.
- Reset asserted mid-stream discards all contents at the next edge.

Decomposition:
- Package mmio_fifo_pkg: register offsets, STATUS bit positions, CTRL bit positions.
- Sub-module sync_fifo (params DEPTH, DW): push/pop/flush, data, full, empty, count. Instantiated twice (TX, RX).
- Top level holds decode, the read mux and the sticky flags.

Test Plan:
- Reset, then read STATUS at BASE+8 -> o_rdata=32'h0000_0005; tx_valid=0; rx_ready=1.
- Store 0xA5A5_0001..0xA5A5_0008 to TXDATA with tx_ready=0 -> STATUS tx_full=1 and tx_count=8. A ninth store sets tx_ovf. Raising tx_ready yields the 8 words in order, then tx_valid=0.
- Drive rx 0x11,0x22 -> two RXDATA loads return 0x11 then 0x22. A third load returns 0 with rx_udf=1. CTRL write 0x4 clears rx_udf.
- TX full with tx_ready=1 and a same-cycle TXDATA store -> tx_count stays 8, no tx_ovf, the new word emerges last.
- Fill RX with 3 words, then a CTRL write of 0x2 concurrent with rx_valid=1 -> rx_count=0 next cycle, rx_empty=1.
- Access BASE+0x10 and BASE+0x2 -> o_hit=0, no FIFO or flag change.

Source files
------------

// File: rtl/mmio_fifo_pkg.sv
// Register map and bit positions shared by the MMIO FIFO port.
package mmio_fifo_pkg;

  localparam logic [3:0] OFF_TXDATA = 4'h0;
  localparam logic [3:0] OFF_RXDATA = 4'h4;
  localparam logic [3:0] OFF_STATUS = 4'h8;
  localparam logic [3:0] OFF_CTRL   = 4'hC;

  localparam int ST_TX_EMPTY = 0;
  localparam int ST_TX_FULL  = 1;
  localparam int ST_RX_EMPTY = 2;
  localparam int ST_RX_FULL  = 3;
  localparam int ST_TX_OVF   = 4;
  localparam int ST_RX_UDF   = 5;
  localparam int ST_RX_OVF   = 6;
  localparam int ST_TX_CNT   = 8;
  localparam int ST_RX_CNT   = 16;

  localparam int CT_FLUSH_TX = 0;
  localparam int CT_FLUSH_RX = 1;
  localparam int CT_CLR      = 2;

endpackage

// File: rtl/mmio_fifo_port_sync_fifo.sv
// Single-clock FIFO with flush; a push on full is taken only
// when a pop retires the head in the same cycle.
module sync_fifo #(
  parameter int DEPTH = 8,
  parameter int DW    = 32,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          push_i,
  input  logic [DW-1:0] din_i,
  input  logic          pop_i,
  input  logic          flush_i,
  output logic [DW-1:0] dout_o,
  output logic          full_o,
  output logic          empty_o,
  output logic [AW:0]   count_o
);

  logic [DW-1:0] mem_q [DEPTH];
  logic [AW-1:0] wptr_q, wptr_d;
  logic [AW-1:0] rptr_q, rptr_d;
  logic [AW:0]   count_q, count_d;
  logic          push_ok, pop_ok;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == (AW+1)'(DEPTH));
  assign count_o = count_q;
  assign dout_o  = mem_q[rptr_q];

  assign pop_ok  = pop_i && !empty_o && !flush_i;
  assign push_ok = push_i && (!full_o || pop_ok) && !flush_i;

  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    if (flush_i) begin
      wptr_d  = '0;
      rptr_d  = '0;
      count_d = '0;
    end else begin
      if (push_ok) wptr_d = wptr_q + 1'b1;
      if (pop_ok)  rptr_d = rptr_q + 1'b1;
      if (push_ok && !pop_ok) count_d = count_q + 1'b1;
      if (pop_ok && !push_ok) count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
    end
  end

  // Storage needs no reset: the empty flag hides stale words.
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wptr_q] <= din_i;
  end

endmodule

// File: rtl/mmio_fifo_port.sv
// Memory-mapped TX/RX FIFO responder on the core data bus,
// with valid/ready stream sides and sticky error flags.
module mmio_fifo_port
  import mmio_fifo_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'hFFFF_0000,
  parameter int          DEPTH     = 8,
  parameter int          DW        = 32,
  localparam int         AW        = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [31:0]   addr,
  input  logic          mem_read,
  input  logic          mem_write,
  input  logic [31:0]   i_wdata,
  output logic [31:0]   o_rdata,
  output logic          o_hit,
  output logic [DW-1:0] tx_data,
  output logic          tx_valid,
  input  logic          tx_ready,
  input  logic [DW-1:0] rx_data,
  input  logic          rx_valid,
  output logic          rx_ready
);

  logic          rd, wr;
  logic [3:0]    off;
  logic          tx_push, tx_pop, tx_flush;
  logic          rx_push, rx_pop, rx_flush;
  logic          tx_full, tx_empty, rx_full, rx_empty;
  logic [AW:0]   tx_cnt, rx_cnt;
  logic [DW-1:0] rx_head;
  logic          tx_ovf_q, tx_ovf_d;
  logic          rx_udf_q, rx_udf_d;
  logic          rx_ovf_q, rx_ovf_d;
  logic          clr;
  logic [31:0]   status;

  assign off   = addr[3:0];
  assign o_hit = (addr[31:4] == BASE_ADDR[31:4]) && (addr[1:0] == 2'b00);
  assign rd    = o_hit && mem_read && !mem_write;
  assign wr    = o_hit && mem_write && !mem_read;

  assign tx_valid = !tx_empty;
  assign rx_ready = !rx_full;

  assign tx_push  = wr && (off == OFF_TXDATA);
  assign tx_pop   = tx_valid && tx_ready;
  assign tx_flush = wr && (off == OFF_CTRL) && i_wdata[CT_FLUSH_TX];
  assign rx_push  = rx_valid && rx_ready;
  assign rx_pop   = rd && (off == OFF_RXDATA);
  assign rx_flush = wr && (off == OFF_CTRL) && i_wdata[CT_FLUSH_RX];
  assign clr      = wr && (off == OFF_CTRL) && i_wdata[CT_CLR];

  sync_fifo #(.DEPTH(DEPTH), .DW(DW)) u_tx (
    .clk(clk), .reset(reset),
    .push_i(tx_push), .din_i(i_wdata[DW-1:0]),
    .pop_i(tx_pop), .flush_i(tx_flush),
    .dout_o(tx_data), .full_o(tx_full),
    .empty_o(tx_empty), .count_o(tx_cnt)
  );

  sync_fifo #(.DEPTH(DEPTH), .DW(DW)) u_rx (
    .clk(clk), .reset(reset),
    .push_i(rx_push), .din_i(rx_data),
    .pop_i(rx_pop), .flush_i(rx_flush),
    .dout_o(rx_head), .full_o(rx_full),
    .empty_o(rx_empty), .count_o(rx_cnt)
  );

  always_comb begin
    status = '0;
    status[ST_TX_EMPTY] = tx_empty;
    status[ST_TX_FULL]  = tx_full;
    status[ST_RX_EMPTY] = rx_empty;
    status[ST_RX_FULL]  = rx_full;
    status[ST_TX_OVF]   = tx_ovf_q;
    status[ST_RX_UDF]   = rx_udf_q;
    status[ST_RX_OVF]   = rx_ovf_q;
    status[ST_TX_CNT +: 8] = 8'(tx_cnt);
    status[ST_RX_CNT +: 8] = 8'(rx_cnt);
  end

  always_comb begin
    o_rdata = '0;
    if (o_hit) begin
      unique case (1'b1)
        (off == OFF_RXDATA): o_rdata = rx_empty ? '0 : 32'(rx_head);
        (off == OFF_STATUS): o_rdata = status;
        default:             o_rdata = '0;
      endcase
    end
  end

  // A clear in the same cycle as a set leaves the flag low.
  always_comb begin
    tx_ovf_d = tx_ovf_q || (tx_push && tx_full && !tx_pop);
    rx_udf_d = rx_udf_q || (rx_pop && rx_empty);
    rx_ovf_d = rx_ovf_q || (rx_valid && rx_full);
    if (clr) begin
      tx_ovf_d = 1'b0;
      rx_udf_d = 1'b0;
      rx_ovf_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      tx_ovf_q <= 1'b0;
      rx_udf_q <= 1'b0;
      rx_ovf_q <= 1'b0;
    end else begin
      tx_ovf_q <= tx_ovf_d;
      rx_udf_q <= rx_udf_d;
      rx_ovf_q <= rx_ovf_d;
    end
  end

endmodule

// File: tb/tb_mmio_fifo_port.sv
// Directed bench for mmio_fifo_port: bus accesses, stream sides,
// sticky flags, flush and decode boundaries.
module tb_mmio_fifo_port;

  localparam logic [31:0] BASE = 32'hFFFF_0000;
  localparam logic [31:0] A_TX = BASE + 32'h0;
  localparam logic [31:0] A_RX = BASE + 32'h4;
  localparam logic [31:0] A_ST = BASE + 32'h8;
  localparam logic [31:0] A_CT = BASE + 32'hC;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] addr;
  logic        mem_read, mem_write;
  logic [31:0] i_wdata, o_rdata;
  logic        o_hit;
  logic [31:0] tx_data;
  logic        tx_valid, tx_ready;
  logic [31:0] rx_data;
  logic        rx_valid, rx_ready;

  int checks = 0;
  int failures = 0;

  logic [31:0] rdv;
  logic        hitv;

  always #5 clk = ~clk;

  mmio_fifo_port #(.BASE_ADDR(BASE), .DEPTH(8), .DW(32)) dut (
    .clk(clk), .reset(reset), .addr(addr),
    .mem_read(mem_read), .mem_write(mem_write),
    .i_wdata(i_wdata), .o_rdata(o_rdata), .o_hit(o_hit),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready)
  );

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic bus(input logic r, input logic w,
                     input logic [31:0] a, input logic [31:0] d,
                     output logic [31:0] rv, output logic h);
    mem_read = r; mem_write = w; addr = a; i_wdata = d;
    #1;
    rv = o_rdata;
    h  = o_hit;
    tick();
    mem_read = 1'b0; mem_write = 1'b0;
    addr = 32'h0; i_wdata = 32'h0;
  endtask

  task automatic st(input logic [31:0] a, input logic [31:0] d);
    bus(1'b0, 1'b1, a, d, rdv, hitv);
  endtask

  task automatic ld(input logic [31:0] a, output logic [31:0] v);
    bus(1'b1, 1'b0, a, 32'h0, v, hitv);
  endtask

  task automatic rx_send(input logic [31:0] d);
    rx_valid = 1'b1; rx_data = d;
    tick();
    rx_valid = 1'b0; rx_data = 32'h0;
  endtask

  initial begin
    reset = 1'b1; addr = 32'h0; mem_read = 1'b0; mem_write = 1'b0;
    i_wdata = 32'h0; tx_ready = 1'b0; rx_data = 32'h0; rx_valid = 1'b0;
    tick(); tick();
    reset = 1'b0;

    ld(A_ST, rdv);
    chk("reset_status", rdv, 32'h0000_0005);
    chk("reset_hit", 32'(hitv), 32'd1);
    chk("reset_tx_valid", 32'(tx_valid), 32'd0);
    chk("reset_rx_ready", 32'(rx_ready), 32'd1);

    for (int k = 1; k <= 8; k++) st(A_TX, 32'hA5A5_0000 + 32'(k));
    ld(A_ST, rdv);
    chk("tx_full_status", rdv, 32'h0000_0806);
    st(A_TX, 32'hDEAD_BEEF);
    ld(A_ST, rdv);
    chk("tx_ovf_status", rdv, 32'h0000_0816);
    tx_ready = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      chk($sformatf("tx_word%0d", k), tx_data, 32'hA5A5_0000 + 32'(k));
      tick();
    end
    chk("tx_drained_valid", 32'(tx_valid), 32'd0);
    tx_ready = 1'b0;
    st(A_CT, 32'h4);
    ld(A_ST, rdv);
    chk("tx_ovf_cleared", rdv, 32'h0000_0005);

    rx_send(32'h11);
    rx_send(32'h22);
    ld(A_ST, rdv);
    chk("rx_two_status", rdv, 32'h0002_0001);
    ld(A_RX, rdv);
    chk("rx_load1", rdv, 32'h11);
    ld(A_RX, rdv);
    chk("rx_load2", rdv, 32'h22);
    ld(A_RX, rdv);
    chk("rx_load_empty", rdv, 32'h0);
    ld(A_ST, rdv);
    chk("rx_udf_status", rdv, 32'h0000_0025);
    st(A_CT, 32'h4);
    ld(A_ST, rdv);
    chk("rx_udf_cleared", rdv, 32'h0000_0005);

    for (int k = 1; k <= 8; k++) st(A_TX, 32'hB000_0000 + 32'(k));
    tx_ready = 1'b1;
    st(A_TX, 32'h0000_C0DE);
    tx_ready = 1'b0;
    ld(A_ST, rdv);
    chk("full_push_pop_status", rdv, 32'h0000_0806);
    tx_ready = 1'b1;
    for (int k = 2; k <= 8; k++) begin
      chk($sformatf("pp_word%0d", k), tx_data, 32'hB000_0000 + 32'(k));
      tick();
    end
    chk("pp_last_word", tx_data, 32'h0000_C0DE);
    tick();
    chk("pp_drained", 32'(tx_valid), 32'd0);
    tx_ready = 1'b0;

    rx_send(32'h1); rx_send(32'h2); rx_send(32'h3);
    ld(A_ST, rdv);
    chk("rx_three_status", rdv, 32'h0003_0001);
    rx_valid = 1'b1; rx_data = 32'h99;
    st(A_CT, 32'h2);
    rx_valid = 1'b0; rx_data = 32'h0;
    ld(A_ST, rdv);
    chk("rx_flush_status", rdv, 32'h0000_0005);

    st(A_TX, 32'h1234_5678);
    bus(1'b0, 1'b1, BASE + 32'h10, 32'h55, rdv, hitv);
    chk("hit_off10", 32'(hitv), 32'd0);
    bus(1'b0, 1'b1, BASE + 32'h2, 32'h66, rdv, hitv);
    chk("hit_off2", 32'(hitv), 32'd0);
    bus(1'b1, 1'b0, BASE + 32'h2, 32'h0, rdv, hitv);
    chk("miss_rdata", rdv, 32'h0);
    ld(A_CT, rdv);
    chk("ctrl_read_zero", rdv, 32'h0);
    st(A_ST, 32'hFFFF_FFFF);
    bus(1'b1, 1'b1, A_TX, 32'h77, rdv, hitv);
    ld(A_ST, rdv);
    chk("no_side_effects", rdv, 32'h0000_0104);
    chk("tx_head_kept", tx_data, 32'h1234_5678);

    st(A_CT, 32'h1);
    for (int k = 0; k < 9; k++) rx_send(32'hC0 + 32'(k));
    ld(A_ST, rdv);
    chk("rx_ovf_status", rdv, 32'h0008_0049);
    chk("rx_full_ready", 32'(rx_ready), 32'd0);
    ld(A_RX, rdv);
    chk("rx_ovf_head", rdv, 32'hC0);
    st(A_CT, 32'h6);
    ld(A_ST, rdv);
    chk("flush_clear_status", rdv, 32'h0000_0005);

    st(A_TX, 32'hAAAA_0001);
    rx_send(32'h5);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    ld(A_ST, rdv);
    chk("midstream_reset", rdv, 32'h0000_0005);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
